sqrt_iter_pipe: RTL

- Parametrised, iterative, restoring digit-by-digit unsigned square root unit. It produces one result bit per clock.
- Generalises the fixed 32-bit square root with enable gating in three ways: configurable radicand width, optional fractional result bits, and a remainder output.
- Adds a valid/ready handshake on both input and output.
- Sits in the datapath as the shared sqrt resource, feeding magnitude/normalisation stages.

---
 rtl/sqrt_iter_pipe_if.sv | 16 +
 rtl/sqrt_iter_pipe.sv | 85 ++++++++
 2 files changed

// File: rtl/sqrt_iter_pipe_if.sv
// sqrt_iter_pipe_if: radicand-in / root-out handshake bundle for the iterative square root unit.
interface sqrt_iter_pipe_if #(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 0
);
   localparam int RES_W = WIDTH/2 + FRAC_BITS;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] sqrt;
   logic [RES_W:0]   rem;
   modport master (output in_valid, a, out_ready, input in_ready, out_valid, sqrt, rem);
   modport slave  (input in_valid, a, out_ready, output in_ready, out_valid, sqrt, rem);
endinterface

// File: rtl/sqrt_iter_pipe.sv
// sqrt_iter_pipe: restoring digit-by-digit unsigned square root, one root bit per enabled clock.
module sqrt_iter_pipe #(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 0
) (
   input logic            clk,
   input logic            rst,
   input logic            EN,
   sqrt_iter_pipe_if.slave bus
);
   localparam int RES_W = WIDTH/2 + FRAC_BITS;
   localparam int SW    = 2*RES_W;
   localparam int CW    = RES_W > 1 ? $clog2(RES_W) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    sh_q, sh_d;
   logic [RES_W-1:0] q_q, q_d, sqrt_q, sqrt_d, qn;
   logic [RES_W+1:0] r_q, r_d, rp, t, rn;
   logic [RES_W:0]   rem_q, rem_d;
   logic             ge, last;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         q_q     <= '0;
         r_q     <= '0;
         sqrt_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         q_q     <= q_d;
         r_q     <= r_d;
         sqrt_q  <= sqrt_d;
         rem_q   <= rem_d;
      end
   end
   always_comb begin
      last    = cnt_q == '0;
      state_d = !EN ? state_q :
                state_q == IDLE ? (bus.in_valid ? CALC : IDLE) :
                state_q == CALC ? (last ? DONE : CALC) :
                (bus.out_ready ? IDLE : DONE);
   end
   always_comb begin
      bus.in_ready  = state_q == IDLE && EN;
      bus.out_valid = state_q == DONE;
      bus.sqrt      = sqrt_q;
      bus.rem       = rem_q;
   end
   // Trial subtraction: bring down two radicand bits, try to append a 1 to the root.
   always_comb begin
      rp = (RES_W+2)'({r_q, sh_q[SW-1 -: 2]});
      t  = {q_q, 2'b01};
      ge = rp >= t;
      rn = ge ? rp - t : rp;
      qn = RES_W'({q_q, ge});
   end
   always_comb begin
      cnt_d  = cnt_q;
      sh_d   = sh_q;
      q_d    = q_q;
      r_d    = r_q;
      sqrt_d = sqrt_q;
      rem_d  = rem_q;
      if (EN && state_q == IDLE && bus.in_valid) begin
         sh_d  = SW'(bus.a) << (2*FRAC_BITS);
         q_d   = '0;
         r_d   = '0;
         cnt_d = CW'(RES_W-1);
      end else if (EN && state_q == CALC) begin
         sh_d  = sh_q << 2;
         q_d   = qn;
         r_d   = rn;
         cnt_d = cnt_q - 1'b1;
         if (last) begin
            sqrt_d = qn;
            rem_d  = rn[RES_W:0];
         end
      end
   end
endmodule
